fp_sgnj: RTL and testbench

- Floating-point sign-injection unit for the RISC-V FPU; implements FSGNJ, FSGNJN and FSGNJX for single (F32) and double (F64) precision.
- Copies the magnitude of operand 1 and computes a new sign from the operation selector.
- Result is registered once; sits in the FPU execute stage beside the compare and move units.

---
 rtl/fp_sgnj.sv | 68 ++++++
 tb/tb_fp_sgnj.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sgnj.sv
// FSGNJ/FSGNJN/FSGNJX sign-injection unit for F32/F64 with a single output register.
// Optional NaN-boxing of F32 operands and results when FP_SGNJ_NANBOX_EN is defined.
module fp_sgnj (
  input  logic        fp_sgnj_i_clk,
  input  logic        fp_sgnj_i_rst_n,
  input  logic        fp_sgnj_i_valid,
  input  logic [63:0] fp_sgnj_i_data1,
  input  logic [63:0] fp_sgnj_i_data2,
  input  logic [1:0]  fp_sgnj_i_fmt,
  input  logic [2:0]  fp_sgnj_i_rm,
  output logic        fp_sgnj_o_valid,
  output logic [63:0] fp_sgnj_o_result
);

  logic [63:0] w_op1;
  logic [63:0] w_op2;
  logic        w_s1;
  logic        w_s2;
  logic        w_sign;
  logic [63:0] w_result;
  logic        r_valid;
  logic [63:0] r_result;

  always_comb begin
    w_op1 = fp_sgnj_i_data1;
    w_op2 = fp_sgnj_i_data2;
`ifdef FP_SGNJ_NANBOX_EN
    // Improperly boxed F32 operands read as the canonical quiet NaN.
    if (fp_sgnj_i_fmt == 2'd0) begin
      if (fp_sgnj_i_data1[63:32] != '1) w_op1 = 64'hFFFF_FFFF_7FC0_0000;
      if (fp_sgnj_i_data2[63:32] != '1) w_op2 = 64'hFFFF_FFFF_7FC0_0000;
    end
`endif
    w_s1 = (fp_sgnj_i_fmt == 2'd1) ? w_op1[63] : w_op1[31];
    w_s2 = (fp_sgnj_i_fmt == 2'd1) ? w_op2[63] : w_op2[31];

    case (fp_sgnj_i_rm)
      3'd0:    w_sign = w_s2;
      3'd1:    w_sign = ~w_s2;
      3'd2:    w_sign = w_s1 ^ w_s2;
      default: w_sign = 1'b0;
    endcase

    case (fp_sgnj_i_fmt)
`ifdef FP_SGNJ_NANBOX_EN
      2'd0:    w_result = {32'hFFFF_FFFF, w_sign, w_op1[30:0]};
`else
      2'd0:    w_result = {32'h0000_0000, w_sign, w_op1[30:0]};
`endif
      2'd1:    w_result = {w_sign, w_op1[62:0]};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge fp_sgnj_i_clk or negedge fp_sgnj_i_rst_n) begin
    if (!fp_sgnj_i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= fp_sgnj_i_valid;
      if (fp_sgnj_i_valid) r_result <= w_result;
    end
  end

  assign fp_sgnj_o_valid  = r_valid;
  assign fp_sgnj_o_result = r_result;

endmodule

// File: tb/tb_fp_sgnj.sv
// Scoreboard bench for fp_sgnj: directed sign-injection cases, random stream, mid-stream reset.
module tb_fp_sgnj;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [63:0] i_data1;
  logic [63:0] i_data2;
  logic [1:0]  i_fmt;
  logic [2:0]  i_rm;
  logic        o_valid;
  logic [63:0] o_result;

  int tests;
  int fails;
  logic [63:0] exp_q[$];
  logic [63:0] exp_held;

`ifdef FP_SGNJ_NANBOX_EN
  localparam logic [31:0] UP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] UP = 32'h0000_0000;
`endif

  fp_sgnj dut (
    .fp_sgnj_i_clk    (clk),
    .fp_sgnj_i_rst_n  (rst_n),
    .fp_sgnj_i_valid  (i_valid),
    .fp_sgnj_i_data1  (i_data1),
    .fp_sgnj_i_data2  (i_data2),
    .fp_sgnj_i_fmt    (i_fmt),
    .fp_sgnj_i_rm     (i_rm),
    .fp_sgnj_o_valid  (o_valid),
    .fp_sgnj_o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [1:0] f, input logic [2:0] r,
                                        input logic [63:0] a, input logic [63:0] b);
    int unsigned w;
    logic [63:0] mag;
    logic [63:0] res;
    bit sa, sb, s;
    if (f > 2'd1) return 64'h0;
    w = (f == 2'd0) ? 32 : 64;
`ifdef FP_SGNJ_NANBOX_EN
    if (f == 2'd0) begin
      if (a[63:32] != 32'hFFFF_FFFF) a = 64'hFFFF_FFFF_7FC0_0000;
      if (b[63:32] != 32'hFFFF_FFFF) b = 64'hFFFF_FFFF_7FC0_0000;
    end
`endif
    sa  = a[w-1];
    sb  = b[w-1];
    mag = a & ((64'd1 << (w-1)) - 64'd1);
    case (r)
      3'd0:    s = sb;
      3'd1:    s = !sb;
      3'd2:    s = (sa != sb);
      default: s = 1'b0;
    endcase
    res = mag | (64'(s) << (w-1));
`ifdef FP_SGNJ_NANBOX_EN
    if (f == 2'd0) res = res | 64'hFFFF_FFFF_0000_0000;
`endif
    return res;
  endfunction

  // Monitor: pop on each valid result, otherwise the result must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: result=%h with empty scoreboard", o_result);
        end else begin
          exp_held = exp_q.pop_front();
          if (o_result !== exp_held) begin
            fails++;
            $display("FAIL result: got %h expected %h", o_result, exp_held);
          end
        end
      end else if (o_result !== exp_held) begin
        fails++;
        $display("FAIL hold: got %h expected %h", o_result, exp_held);
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [2:0] r,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    @(posedge clk); #1;
    i_valid = 1'b1; i_fmt = f; i_rm = r; i_data1 = a; i_data2 = b;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data1 = {$urandom, $urandom};
    i_data2 = {$urandom, $urandom};
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    logic [63:0] a, b;
    logic [1:0]  f;
    logic [2:0]  r;
    tests = 0; fails = 0; exp_held = '0;
    rst_n = 1'b0; i_valid = 1'b0; i_fmt = '0; i_rm = '0; i_data1 = '0; i_data2 = '0;
    #2;
    check("reset_valid", 64'(o_valid), 64'h0);
    check("reset_result", o_result, 64'h0);
    #21 rst_n = 1'b1;
    repeat (2) idle();

    issue(2'd0, 3'd0, {UP, 32'h3f800000}, {UP, 32'hbf800000}, {UP, 32'hbf800000});
    idle(); idle();

    issue(2'd0, 3'd0, {UP, 32'h92345678}, {UP, 32'hbf800000}, {UP, 32'h92345678});
    issue(2'd0, 3'd1, {UP, 32'h92345678}, {UP, 32'hbf800000}, {UP, 32'h12345678});
    issue(2'd0, 3'd2, {UP, 32'h92345678}, {UP, 32'hbf800000}, {UP, 32'h12345678});
    issue(2'd0, 3'd2, {UP, 32'h92345678}, {UP, 32'h3f800000}, {UP, 32'h92345678});

    issue(2'd1, 3'd0, 64'h7ff0000000000000, 64'hfff0000000000000, 64'hfff0000000000000);
    issue(2'd1, 3'd1, 64'h7ff0000000000000, 64'hfff0000000000000, 64'h7ff0000000000000);
    issue(2'd1, 3'd2, 64'h7ff0000000000000, 64'hfff0000000000000, 64'hfff0000000000000);
    issue(2'd1, 3'd2, 64'h8123456789abcdef, 64'h0, 64'h8123456789abcdef);
    issue(2'd1, 3'd5, 64'hbff0000000000000, 64'hbff0000000000000, 64'h3ff0000000000000);
    idle();

    for (int fi = 2; fi < 4; fi++)
      for (int ri = 0; ri < 8; ri++)
        issue(2'(fi), 3'(ri), {$urandom, $urandom}, {$urandom, $urandom}, 64'h0);
    idle();

`ifdef FP_SGNJ_NANBOX_EN
    issue(2'd0, 3'd0, 64'h00000000_3f800000, 64'hFFFFFFFF_bf800000, 64'hFFFFFFFF_FFC00000);
    idle();
`endif

    for (int n = 0; n < 500; n++) begin
      f = 2'($urandom_range(0, 1));
      r = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (f == 2'd0 && $urandom_range(0, 3) != 0) begin
        a[63:32] = UP;
        b[63:32] = UP;
      end
      issue(f, r, a, b, model(f, r, a, b));
    end

    // Reset while a valid result is on the output.
    issue(2'd1, 3'd1, 64'h0123456789abcdef, 64'h0, 64'h8123456789abcdef);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("pre_reset_valid", 64'(o_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(o_valid), 64'h0);
    check("midreset_result", o_result, 64'h0);
    exp_q.delete();
    exp_held = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) idle();

    issue(2'd0, 3'd1, {UP, 32'h3f800000}, {UP, 32'h3f800000}, {UP, 32'hbf800000});
    repeat (3) idle();

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
